instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 98 +++++++++
 tb/tb_instr_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding 16-bit fetch, a registered instruction
// slot held until decode accepts it, and redirect handling that drops stale responses.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] req_addr_q;
  logic        req_q;
  logic [15:0] instr_q;
  logic [15:0] instr_pc_q;
  logic        instr_valid_q;
  logic [15:0] tgt;

  assign tgt         = redirect_pc & 16'hFFFE;
  assign imem_req    = req_q;
  assign imem_addr   = req_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      req_q         <= 1'b0;
      instr_q       <= 16'h0000;
      instr_pc_q    <= 16'h0000;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          // req_q low here only in the first cycle after reset: nothing is outstanding yet
          if (!req_q) begin
            req_q <= 1'b1;
            if (redirect) begin
              pc_q       <= tgt;
              req_addr_q <= tgt;
            end
          end else if (redirect) begin
            pc_q <= tgt;
            if (imem_rvalid) req_addr_q <= tgt;
            else             state_q    <= DROP;
          end else if (imem_rvalid) begin
            instr_q       <= imem_rdata;
            instr_pc_q    <= req_addr_q;
            instr_valid_q <= 1'b1;
            pc_q          <= req_addr_q + PC_STEP;
            req_q         <= 1'b0;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            instr_valid_q <= 1'b0;
            pc_q          <= tgt;
            req_addr_q    <= tgt;
            req_q         <= 1'b1;
            state_q       <= FETCH;
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
            req_addr_q    <= pc_q;
            req_q         <= 1'b1;
            state_q       <= FETCH;
          end
        end
        DROP: begin
          // Old request still in flight; the newest redirect target wins
          if (redirect) pc_q <= tgt;
          if (imem_rvalid) begin
            req_addr_q <= redirect ? tgt : pc_q;
            state_q    <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue of expected fetched instructions.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle memory response; accepted responses go on the scoreboard
  task automatic respond(input logic [15:0] data, input logic [15:0] addr, input bit accept);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    if (accept) sb_q.push_back({addr, data});
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
  endtask

  task automatic expect_out(input string tag);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_novalid"}, {31'd0, instr_valid}, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, "_instr"}, {16'd0, instr}, {16'd0, e[15:0]});
      chk({tag, "_pc"},    {16'd0, instr_pc}, {16'd0, e[31:16]});
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [15:0] addr);
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, "_addr"}, {16'd0, imem_addr}, {16'd0, addr});
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_rvalid = 1'b0; imem_rdata = 16'h0000; instr_ready = 1'b0;
    #3;
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr},       32'd0);
    chk("rst_ipc",   {16'd0, instr_pc},    32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_req("post_rst", 1'b1, 16'h0000);

    // First fetch, response one cycle after the request appears
    tick();
    chk_req("first_wait", 1'b1, 16'h0000);
    respond(16'h1234, 16'h0000, 1'b1);
    expect_out("first");
    chk_req("hold0", 1'b0, 16'h0000);

    // Decode stalls five cycles; a stray response in HOLD is ignored
    for (int i = 0; i < 5; i++) begin
      if (i == 2) respond(16'hDEAD, 16'h0000, 1'b0);
      else        tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", {16'd0, instr},       32'h1234);
      chk("stall_ipc",   {16'd0, instr_pc},    32'h0000);
      chk("stall_req",   {31'd0, imem_req},    32'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("rel_valid", {31'd0, instr_valid}, 32'd0);
    chk_req("next_fetch", 1'b1, 16'h0002);

    respond(16'hABCD, 16'h0002, 1'b1);
    expect_out("second");
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk_req("third_fetch", 1'b1, 16'h0004);

    // Redirect with request pending: old response dropped, then fetch 0x0040
    redirect = 1'b1; redirect_pc = 16'h0041;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_req("drop_wait", 1'b1, 16'h0004);
      expect_out("drop_wait");
      tick();
    end
    chk_req("drop_wait2", 1'b1, 16'h0004);
    respond(16'hBEEF, 16'h0004, 1'b0);
    expect_out("dropped");
    chk("drop_instr_kept", {16'd0, instr}, 32'hABCD);
    chk_req("after_drop", 1'b1, 16'h0040);

    // Redirect in the same cycle as the response
    redirect = 1'b1; redirect_pc = 16'h0100;
    respond(16'h1111, 16'h0040, 1'b0);
    redirect = 1'b0;
    expect_out("same_cycle");
    chk_req("same_cycle", 1'b1, 16'h0100);

    // Two redirects while dropping: the newest target is fetched
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect_pc = 16'h0300;
    tick();
    redirect = 1'b0;
    chk_req("drop_twice", 1'b1, 16'h0100);
    respond(16'h2222, 16'h0100, 1'b0);
    expect_out("drop_twice");
    chk_req("drop_twice_new", 1'b1, 16'h0300);

    // Redirect to 0xFFFF (bit 0 cleared), then PC wraps to 0x0000
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    respond(16'h3333, 16'h0300, 1'b0);
    redirect = 1'b0;
    chk_req("to_fffe", 1'b1, 16'hFFFE);
    respond(16'h5A5A, 16'hFFFE, 1'b1);
    expect_out("wrap");
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk_req("wrap_next", 1'b1, 16'h0000);

    // Redirect in HOLD beats instr_ready
    respond(16'h7777, 16'h0000, 1'b1);
    expect_out("hold_redir");
    redirect = 1'b1; redirect_pc = 16'h0123; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    chk("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
    chk_req("hold_redir", 1'b1, 16'h0122);

    // Asynchronous reset while holding an instruction
    respond(16'h4321, 16'h0122, 1'b1);
    expect_out("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_req",   {31'd0, imem_req},    32'd0);
    chk("async_instr", {16'd0, instr},       32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_req("rerun", 1'b1, 16'h0000);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
